// File: rtl/byte_word_bridge.sv
// Byte<->word bridge: RX packs 4 bytes into a 32-bit word, TX serialises a word into 4 bytes.
// Define BYTE_WORD_BRIDGE_BIG_ENDIAN_EN for big-endian lane order (default little-endian).
module byte_word_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic        byte_in_ready,
    output logic [31:0] word_out,
    output logic        word_out_valid,
    input  logic        word_out_ready,
    input  logic [31:0] word_in,
    input  logic        word_in_valid,
    output logic        word_in_ready,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    input  logic        byte_out_ready
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    // Lane index -> byte position within the word
    function automatic logic [BYTE_W-1:0] f_get_lane(input logic [WORD_W-1:0] w,
                                                    input logic [LANE_W-1:0] i);
        logic [BYTE_W-1:0] b;
        case (i)
`ifdef BYTE_WORD_BRIDGE_BIG_ENDIAN_EN
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
`else
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
`endif
        endcase
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] f_set_lane(input logic [WORD_W-1:0] w,
                                                    input logic [LANE_W-1:0] i,
                                                    input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = w;
        case (i)
`ifdef BYTE_WORD_BRIDGE_BIG_ENDIAN_EN
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
`else
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
`endif
        endcase
        return r;
    endfunction

    logic [LANE_W-1:0] r_cnt;
    logic [WORD_W-1:0] r_asm;
    logic              r_asm_full;
    logic [WORD_W-1:0] r_word_out;
    logic              r_word_out_valid;

    logic              w_byte_acc;
    logic              w_drain;
    logic [WORD_W-1:0] w_asm_next;

    assign w_byte_acc = byte_in_valid & ~r_asm_full;
    assign w_drain    = r_word_out_valid & word_out_ready;
    assign w_asm_next = f_set_lane(r_asm, r_cnt, byte_in);

    // RX assembly with one word of overflow storage behind the output buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt            <= '0;
            r_asm            <= '0;
            r_asm_full       <= 1'b0;
            r_word_out       <= '0;
            r_word_out_valid <= 1'b0;
        end else if (flush) begin
            r_cnt            <= '0;
            r_asm            <= '0;
            r_asm_full       <= 1'b0;
            r_word_out       <= '0;
            r_word_out_valid <= 1'b0;
        end else if (r_asm_full) begin
            if (w_drain) begin
                r_word_out <= r_asm;
                r_asm_full <= 1'b0;
                r_cnt      <= '0;
            end
        end else if (w_byte_acc) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                if (!r_word_out_valid || w_drain) begin
                    r_word_out       <= w_asm_next;
                    r_word_out_valid <= 1'b1;
                end else begin
                    r_asm      <= w_asm_next;
                    r_asm_full <= 1'b1;
                end
            end else begin
                r_asm <= w_asm_next;
                if (w_drain) r_word_out_valid <= 1'b0;
            end
        end else if (w_drain) begin
            r_word_out_valid <= 1'b0;
        end
    end

    tx_state_t         r_tx_state;
    logic [WORD_W-1:0] r_tx_word;
    logic [LANE_W-1:0] r_lane;
    logic [BYTE_W-1:0] r_byte_out;
    logic              r_byte_out_valid;

    // TX serialiser; byte_out is preloaded so it is valid the cycle after capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state       <= TX_IDLE;
            r_tx_word        <= '0;
            r_lane           <= '0;
            r_byte_out       <= '0;
            r_byte_out_valid <= 1'b0;
        end else if (flush) begin
            r_tx_state       <= TX_IDLE;
            r_tx_word        <= '0;
            r_lane           <= '0;
            r_byte_out       <= '0;
            r_byte_out_valid <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (word_in_valid) begin
                        r_tx_word        <= word_in;
                        r_lane           <= '0;
                        r_byte_out       <= f_get_lane(word_in, 2'd0);
                        r_byte_out_valid <= 1'b1;
                        r_tx_state       <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (byte_out_ready) begin
                        if (r_lane == 2'd3) begin
                            r_byte_out_valid <= 1'b0;
                            r_tx_state       <= TX_IDLE;
                        end else begin
                            r_lane     <= r_lane + 2'd1;
                            r_byte_out <= f_get_lane(r_tx_word, r_lane + 2'd1);
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign byte_in_ready  = ~r_asm_full;
    assign word_out       = r_word_out;
    assign word_out_valid = r_word_out_valid;
    assign word_in_ready  = (r_tx_state == TX_IDLE);
    assign byte_out       = r_byte_out;
    assign byte_out_valid = r_byte_out_valid;

endmodule
